switch: RTL and testbench
=========================

Name: switch

Overview:
- Self-contained 4-port packet switch used as the scan-insertion (DFT) demonstration block.
- An internal 16-bit LFSR generates one packet per cycle. Each packet is routed to one of four 8-bit output registers, and a per-port 4-bit delivery counter is kept.
- All 64 state flops form a single mux-D scan chain. The scan chain is the only observation path: scan_in0 in, scan_out0 out.

Parameters:
- none. All widths are fixed: 64-flop chain, 4 ports, 8-bit data.

Ports:
- clk  input  1  rising-edge clock for all flops
- reset  input  1  synchronous, active-high reset
- scan_in0  input  1  serial scan data into chain bit 0
- scan_en  input  1  scan shift enable; effective only when test_mode=1
- test_mode  input  1  DFT mode select
- scan_out0  output  1  chain bit 63 (cnt3[3]), driven directly from the flop with no logic

Behaviour:
- State registers:
  - lfsr[15:0]
  - out0..out3, each [7:0]
  - cnt0..cnt3, each [3:0]
- Chain order, bit 0 to bit 63:
  - lfsr[0..15]
  - out0[0..7], out1[0..7], out2[0..7], out3[0..7]
  - cnt0[0..3], cnt1[0..3], cnt2[0..3], cnt3[0..3]
  - Example positions: chain[16] = out0[0]; chain[48] = cnt0[0]; chain[63] = cnt3[3].
- Mode decode, evaluated every rising clk edge in priority order:
  1. shift = test_mode & scan_en. If shift: chain[0] <= scan_in0; chain[i] <= chain[i-1] for i = 1..63. reset is ignored while shift=1 so a shift is never corrupted.
  2. Else if reset: lfsr <= 16'hACE1; all out regs <= 8'h00; all counters <= 4'h0.
  3. Else functional update (below).
- When test_mode=0, scan_en is don't-care and the block is always functional or in reset.
- Functional update, computed from pre-edge values:
  - fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]
  - lfsr <= {lfsr[14:0], fb}
  - dest = lfsr[9:8]; data = lfsr[7:0]
  - out[dest] <= data; cnt[dest] <= cnt[dest]+1, wrapping 15 -> 0
  - Non-selected out and cnt registers hold.
- Exactly one port is updated per functional cycle. No back-pressure, no handshake.
- Latency:
  - A packet appears in its out register 1 cycle after the LFSR state that generated it.
  - scan_out0 reflects chain[63] immediately after each edge.
- Reset output value: scan_out0 = 0.
- Reset mid-shift (test_mode=1, scan_en=1): shifting continues and reset has no effect. Dropping scan_en with reset still high resets on that edge.
- Capture cycle: test_mode=1, scan_en=0 performs a normal functional update (reset applies if asserted). This allows shift-capture-shift testing.
- Before the first reset, state is undefined. No power-on initialisation is required.

Test Plan:
- Reset then scan-out: reset=1 for 1 cycle, then test_mode=1, scan_en=1, scan_in0=0 for 64 cycles.
  - First 48 bits observed are 0.
  - Final 16 bits, in order, are lfsr[15..0] = 1010_1100_1110_0001 (0xACE1).
- One functional cycle: reset, then 1 cycle with reset=0 and scan_en=0, then shift out 64 bits.
  - lfsr = 0x59C3, out0 = 0xE1, cnt0 = 1; all other out and cnt registers are 0.
  - Bit sequence: 12 zeros (cnt3..cnt1), then 0001 (cnt0 [3..0]), then 24 zeros, then 1110_0001 (out0 [7..0]), then 0101_1001_1100_0011.
- Chain flush/integrity: test_mode=1, scan_en=1, shift in 0x0123_4567_89AB_CDEF MSB-first over 64 cycles, then shift 64 more.
  - Same 64-bit pattern emerges on scan_out0 MSB-first, with no bit lost or duplicated.
- Shift precedence over reset: during a shift, hold reset=1 for 10 cycles mid-stream.
  - Shifted-out data is identical to the no-reset run.
- test_mode gating: test_mode=0, scan_en=1 for 20 cycles after reset, then scan-out.
  - State equals 20 functional cycles. The sum of cnt0..cnt3 equals 20 mod 16 per-port wrap-consistent with a software LFSR model.
- Counter wrap: run 200 functional cycles, then compare the full 64-bit scan image against the reference model, including at least one port counter that wrapped past 15.

Source files
------------

// File: rtl/switch.sv
// 4-port LFSR-fed packet switch with all 64 state flops on one mux-D scan chain.
// Latency: a packet lands in its out register 1 cycle after its LFSR state; scan_out0 is chain[63] after each edge.
// Backpressure: none; one port is written every functional cycle, no handshake.
module switch (
    input  logic clk,
    input  logic reset,
    input  logic scan_in0,
    input  logic scan_en,
    input  logic test_mode,
    output logic scan_out0
);

    logic [15:0] lfsr;
    logic [7:0]  out0, out1, out2, out3;
    logic [3:0]  cnt0, cnt1, cnt2, cnt3;

    logic        shift;
    logic        fb;
    logic [1:0]  dest;
    logic [7:0]  data;

    assign shift = test_mode & scan_en;
    assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign dest  = lfsr[9:8];
    assign data  = lfsr[7:0];

    // Shift has priority over reset so an in-flight scan load/unload is never corrupted.
    always_ff @(posedge clk) begin
        if (shift) begin
            {cnt3, cnt2, cnt1, cnt0, out3, out2, out1, out0, lfsr} <=
                {cnt3[2:0], cnt2, cnt1, cnt0, out3, out2, out1, out0, lfsr, scan_in0};
        end else if (reset) begin
            lfsr <= 16'hACE1;
            out0 <= 8'h00;
            out1 <= 8'h00;
            out2 <= 8'h00;
            out3 <= 8'h00;
            cnt0 <= 4'h0;
            cnt1 <= 4'h0;
            cnt2 <= 4'h0;
            cnt3 <= 4'h0;
        end else begin
            lfsr <= {lfsr[14:0], fb};
            case (dest)
                2'd0: begin
                    out0 <= data;
                    cnt0 <= cnt0 + 4'd1;
                end
                2'd1: begin
                    out1 <= data;
                    cnt1 <= cnt1 + 4'd1;
                end
                2'd2: begin
                    out2 <= data;
                    cnt2 <= cnt2 + 4'd1;
                end
                default: begin
                    out3 <= data;
                    cnt3 <= cnt3 + 4'd1;
                end
            endcase
        end
    end

    assign scan_out0 = cnt3[3];

endmodule

// File: tb/tb_switch.sv
// Directed bench for switch: state is observed only through 64-cycle scan unloads.
module tb_switch;

    logic clk;
    logic reset;
    logic scan_in0;
    logic scan_en;
    logic test_mode;
    logic scan_out0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] RESET_IMG = {48'h0, 16'hACE1};
    localparam logic [63:0] PAT       = 64'h0123_4567_89AB_CDEF;

    switch dut (
        .clk       (clk),
        .reset     (reset),
        .scan_in0  (scan_in0),
        .scan_en   (scan_en),
        .test_mode (test_mode),
        .scan_out0 (scan_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic        tm;
        logic        se;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        test_mode = 1'b0;
        scan_en   = 1'b0;
        tick();
        reset     = 1'b0;
    endtask

    task automatic run_func(input int n, input logic tm, input logic se);
        test_mode = tm;
        scan_en   = se;
        repeat (n) tick();
        test_mode = 1'b0;
        scan_en   = 1'b0;
    endtask

    // Image bit i is chain[i]; the first bit observed is chain[63].
    task automatic scan(input logic [63:0] pin, input int rst_from, input int rst_to,
                        output logic [63:0] pout);
        test_mode = 1'b1;
        scan_en   = 1'b1;
        for (int k = 0; k < 64; k++) begin
            scan_in0      = pin[63-k];
            reset         = (k >= rst_from) && (k < rst_to);
            pout[63-k]    = scan_out0;
            tick();
        end
        reset     = 1'b0;
        scan_en   = 1'b0;
        test_mode = 1'b0;
        scan_in0  = 1'b0;
    endtask

    function automatic logic [63:0] model_step(input logic [63:0] s);
        logic [63:0] r;
        logic [15:0] l;
        logic [1:0]  d;
        r = s;
        l = s[15:0];
        d = l[9:8];
        r[16 + 8*d +: 8] = l[7:0];
        r[48 + 4*d +: 4] = s[48 + 4*d +: 4] + 4'd1;
        r[15:0] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return r;
    endfunction

    function automatic logic [63:0] model_run(input int n);
        logic [63:0] s;
        s = RESET_IMG;
        for (int i = 0; i < n; i++) s = model_step(s);
        return s;
    endfunction

    logic [63:0] img;
    logic [63:0] dummy;
    logic [4:0]  csum;

    initial begin
        reset = 1'b0; scan_in0 = 1'b0; scan_en = 1'b0; test_mode = 1'b0;

        vecs[0] = '{"reset_img",   0,   1'b0, 1'b0, RESET_IMG};
        vecs[1] = '{"func1",       1,   1'b0, 1'b0, 64'h0001_0000_00E1_59C3};
        vecs[2] = '{"capture2",    2,   1'b1, 1'b0, 64'h0011_0000_C3E1_B387};
        vecs[3] = '{"gated3",      3,   1'b0, 1'b1, 64'h1011_8700_C3E1_670F};
        vecs[4] = '{"gated20",     20,  1'b0, 1'b1, model_run(20)};
        vecs[5] = '{"wrap200",     200, 1'b0, 1'b0, model_run(200)};
        vecs[6] = '{"capture37",   37,  1'b1, 1'b0, model_run(37)};

        tick();
        for (int i = 0; i < 7; i++) begin
            do_reset();
            check({vecs[i].name, "_so_after_reset"}, {63'h0, scan_out0}, 64'h0);
            run_func(vecs[i].n, vecs[i].tm, vecs[i].se);
            scan(64'h0, -1, -1, img);
            check(vecs[i].name, img, vecs[i].exp);
            if (vecs[i].n == 20) begin
                csum = img[51:48] + img[55:52] + img[59:56] + img[63:60];
                check("gated20_cnt_sum_mod16", {60'h0, csum[3:0]}, 64'd4);
            end
        end

        // Chain integrity: pattern loaded then unloaded intact, chain left clean.
        scan(PAT, -1, -1, dummy);
        scan(64'h0, -1, -1, img);
        check("flush_pattern", img, PAT);
        scan(64'h0, -1, -1, img);
        check("flush_zeros", img, 64'h0);

        // Reset held mid-shift must not disturb the unload.
        scan(PAT, -1, -1, dummy);
        scan(64'h0, 20, 30, img);
        check("shift_over_reset", img, PAT);

        // Dropping scan_en with reset still high resets on that edge.
        scan(PAT, -1, -1, dummy);
        test_mode = 1'b1; scan_en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; test_mode = 1'b0;
        scan(64'h0, -1, -1, img);
        check("reset_on_scan_en_drop", img, RESET_IMG);

        // Shift-capture-shift: one functional update from a scanned-in state.
        scan(PAT, -1, -1, dummy);
        test_mode = 1'b1; scan_en = 1'b0;
        tick();
        test_mode = 1'b0;
        scan(64'h0, -1, -1, img);
        check("capture_from_pattern", img, model_step(PAT));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
